// File: rtl/reg_sequencer.sv
// Multi-cycle control sequencer for the RegBlock datapath: FETCH/DECODE/EXEC/MEM/WB/HALT.
// Strobes are registered from the next state; only ir_write follows mem_ready within the cycle.
module reg_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic        alu_go,
  output logic        mary_write,
  output logic        shelley_write,
  output logic        comp_write,
  output logic        ra_write,
  output logic [1:0]  mary_src,
  output logic [1:0]  shelley_src,
  output logic        ra_src,
  output logic        halted,
  output logic        bus_error,
  output logic [2:0]  state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t         cur, nxt;
  logic [3:0]     opcode, opc_nxt;
  logic [CW-1:0]  wait_cnt, cnt_nxt, cnt_inc;
  logic           err_nxt;
  logic [3:0]     wb_we;
  logic [1:0]     wb_msrc, wb_ssrc;
  logic           wb_rsrc;
  logic           unused_rdata;

  assign unused_rdata = ^mem_rdata[11:0];
  assign cnt_inc      = wait_cnt + 1'b1;
  assign state        = cur;
  // mem_req is low for the first FETCH cycle after reset, so nothing is accepted then
  assign ir_write     = (cur == FETCH) && mem_req && mem_ready;

  always_comb begin
    nxt     = cur;
    opc_nxt = opcode;
    cnt_nxt = wait_cnt;
    err_nxt = bus_error;
    case (cur)
      FETCH: begin
        if (mem_req) begin
          if (mem_ready) begin
            nxt     = DECODE;
            opc_nxt = mem_rdata[15:12];
          end else begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == CW'(TIMEOUT)) begin
              nxt     = HALT;
              err_nxt = 1'b1;
            end
          end
        end
      end
      DECODE: begin
        cnt_nxt = '0;
        case (opcode)
          4'h1, 4'h5:              nxt = EXEC;
          4'h0, 4'h4, 4'h6:        nxt = MEM;
          4'h2, 4'h3, 4'h7, 4'h8:  nxt = WB;
          default:                 nxt = HALT;
        endcase
      end
      EXEC: nxt = WB;
      MEM: begin
        if (mem_ready) begin
          nxt = WB;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == CW'(TIMEOUT)) begin
            nxt     = HALT;
            err_nxt = 1'b1;
          end
        end
      end
      WB: begin
        nxt     = FETCH;
        cnt_nxt = '0;
      end
      HALT:    nxt = HALT;
      default: nxt = HALT;
    endcase
  end

  // Write-enable pattern {mary, shelley, comp, ra} and sources for the WB cycle
  always_comb begin
    wb_we   = 4'b0000;
    wb_msrc = 2'b00;
    wb_ssrc = 2'b00;
    wb_rsrc = 1'b0;
    case (opc_nxt)
      4'h0: wb_we = 4'b1000;
      4'h1: begin wb_we = 4'b1000; wb_msrc = 2'b01; end
      4'h2: begin wb_we = 4'b1000; wb_msrc = 2'b11; end
      4'h3: begin wb_we = 4'b0100; wb_ssrc = 2'b01; end
      4'h4: wb_we = 4'b0100;
      4'h5: wb_we = 4'b0010;
      4'h6: wb_we = 4'b0001;
      4'h7: begin wb_we = 4'b0001; wb_rsrc = 1'b1; end
      4'h8: begin wb_we = 4'b1100; wb_msrc = 2'b10; wb_ssrc = 2'b10; end
      default: wb_we = 4'b0000;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur           <= FETCH;
      opcode        <= 4'h0;
      wait_cnt      <= '0;
      bus_error     <= 1'b0;
      halted        <= 1'b0;
      mem_req       <= 1'b0;
      mem_addr_sel  <= 1'b0;
      pc_write      <= 1'b0;
      alu_go        <= 1'b0;
      mary_write    <= 1'b0;
      shelley_write <= 1'b0;
      comp_write    <= 1'b0;
      ra_write      <= 1'b0;
      mary_src      <= 2'b00;
      shelley_src   <= 2'b00;
      ra_src        <= 1'b0;
    end else begin
      cur          <= nxt;
      opcode       <= opc_nxt;
      wait_cnt     <= cnt_nxt;
      bus_error    <= err_nxt;
      halted       <= (nxt == HALT);
      mem_req      <= (nxt == FETCH) || (nxt == MEM);
      mem_addr_sel <= (nxt == MEM);
      pc_write     <= (nxt == WB);
      alu_go       <= (nxt == EXEC);
      if (nxt == WB) begin
        {mary_write, shelley_write, comp_write, ra_write} <= wb_we;
        mary_src    <= wb_msrc;
        shelley_src <= wb_ssrc;
        ra_src      <= wb_rsrc;
      end else begin
        {mary_write, shelley_write, comp_write, ra_write} <= 4'b0000;
        mary_src    <= 2'b00;
        shelley_src <= 2'b00;
        ra_src      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_sequencer.sv
// Randomized instruction stream against a table-driven model; a negedge monitor scores DUT events.
module tb_reg_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_addr_sel, ir_write, pc_write, alu_go;
  logic        mary_write, shelley_write, comp_write, ra_write;
  logic [1:0]  mary_src, shelley_src;
  logic        ra_src, halted, bus_error;
  logic [2:0]  state;

  reg_sequencer #(.TIMEOUT(15)) dut (
    .clock(clock), .reset_n(reset_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_addr_sel(mem_addr_sel), .ir_write(ir_write),
    .pc_write(pc_write), .alu_go(alu_go), .mary_write(mary_write),
    .shelley_write(shelley_write), .comp_write(comp_write), .ra_write(ra_write),
    .mary_src(mary_src), .shelley_src(shelley_src), .ra_src(ra_src),
    .halted(halted), .bus_error(bus_error), .state(state)
  );

  always #5 clock = ~clock;

  // kind: 0 = ALU operate, 1 = write-back, 2 = halt
  typedef struct packed {
    int         kind;
    logic [3:0] we;
    logic [1:0] msrc;
    logic [1:0] ssrc;
    logic       rsrc;
    logic       berr;
    int         gap;
    int         memcyc;
    int         fetchrun;
  } ev_t;

  ev_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Instruction semantics table: path taken, cycles from ir_write, and the WB register writes.
  function automatic void model(input logic [3:0] op, input int dmem);
    ev_t e;
    e = '0;
    e.gap = -1; e.memcyc = 0; e.fetchrun = -1;
    e.kind = 1;
    case (op)
      4'h0: begin e.we = 4'b1000; e.msrc = 2'd0; end
      4'h1: begin e.we = 4'b1000; e.msrc = 2'd1; end
      4'h2: begin e.we = 4'b1000; e.msrc = 2'd3; end
      4'h3: begin e.we = 4'b0100; e.ssrc = 2'd1; end
      4'h4: begin e.we = 4'b0100; e.ssrc = 2'd0; end
      4'h5: e.we = 4'b0010;
      4'h6: begin e.we = 4'b0001; e.rsrc = 1'b0; end
      4'h7: begin e.we = 4'b0001; e.rsrc = 1'b1; end
      4'h8: begin e.we = 4'b1100; e.msrc = 2'd2; e.ssrc = 2'd2; end
      default: begin e.kind = 2; e.berr = 1'b0; end
    endcase
    if (op == 4'h1 || op == 4'h5) begin
      ev_t x;
      x = '0; x.kind = 0; x.gap = 2; x.memcyc = 0; x.fetchrun = -1;
      exp_q.push_back(x);
      e.gap = 3;
    end else if (op == 4'h0 || op == 4'h4 || op == 4'h6) begin
      e.gap = 3 + dmem;
      e.memcyc = dmem + 1;
    end else begin
      e.gap = 2;
    end
    exp_q.push_back(e);
  endfunction

  function automatic bit is_mem_op(input logic [3:0] op);
    return (op == 4'h0 || op == 4'h4 || op == 4'h6);
  endfunction

  // Monitor: samples on the falling edge, pops an expectation for every observable event
  initial begin
    int last_ir = 0, memrun = 0, fetchrun = 0, act_kind;
    bit prev_halt = 1'b0;
    ev_t e;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset_n) begin
        memrun = 0; fetchrun = 0; prev_halt = 1'b0;
        continue;
      end
      if (mem_req && mem_addr_sel) memrun++;
      if (mem_req && !mem_addr_sel) fetchrun++;
      if (ir_write) begin last_ir = cyc; memrun = 0; fetchrun = 0; end
      if (alu_go || pc_write || (halted && !prev_halt)) begin
        act_kind = halted ? 2 : (pc_write ? 1 : 0);
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_event: got kind %0d expected none", act_kind);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", act_kind, e.kind);
          if (e.gap >= 0) check("latency_from_ir_write", cyc - last_ir, e.gap);
          if (e.kind == 1) begin
            check("write_enables", {mary_write, shelley_write, comp_write, ra_write}, e.we);
            check("src_selects", {mary_src, shelley_src, ra_src}, {e.msrc, e.ssrc, e.rsrc});
            check("mem_cycles", memrun, e.memcyc);
          end
          if (e.kind == 2) begin
            check("halt_bus_error", bus_error, e.berr);
            if (e.fetchrun >= 0) check("timeout_wait_cycles", fetchrun, e.fetchrun);
          end
        end
      end
      if (pc_write) fetchrun = 0;
      if (!pc_write)
        check("quiet_outside_wb", {mary_write, shelley_write, comp_write, ra_write,
                                   mary_src, shelley_src, ra_src}, 0);
      if (halted)
        check("halt_quiet", {mem_req, ir_write, pc_write, alu_go, state}, {4'b0000, 3'd5});
      prev_halt = halted;
    end
  end

  // Wait for a request of the given kind, stall dly cycles, then acknowledge once.
  task automatic serve(input bit sel, input int dly, input logic [15:0] data);
    int t = 0;
    do begin
      @(posedge clock); #1; t++;
    end while (!(mem_req && mem_addr_sel == sel) && t < 200);
    if (t >= 200) begin
      vectors++; miscompares++;
      $display("FAIL serve_wait: got no request sel=%0d expected one within 200 cycles", sel);
      return;
    end
    repeat (dly) begin @(posedge clock); #1; end
    mem_rdata = data;
    mem_ready = 1'b1;
    @(posedge clock); #1;
    mem_ready = 1'b0;
    mem_rdata = 16'($urandom);
  endtask

  task automatic issue(input logic [15:0] instr, input int dfetch, input int dmem);
    model(instr[15:12], dmem);
    serve(1'b0, dfetch, instr);
    if (is_mem_op(instr[15:12])) serve(1'b1, dmem, 16'($urandom));
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin @(posedge clock); #1; t++; end
    if (exp_q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL drain: got %0d pending events expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pulse_reset();
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    check("reset_state", state, 3'd0);
    check("reset_flags", {bus_error, halted}, 2'b00);
    check("reset_strobes", {mem_req, mem_addr_sel, pc_write, alu_go, mary_write,
                            shelley_write, comp_write, ra_write, mary_src, shelley_src, ra_src}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("first_edge_fetch", {state, mem_req, mem_addr_sel}, {3'd0, 1'b1, 1'b0});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] op;
    int t;
    ev_t e;
    #1;
    check("power_on_reset", {state, mem_req, bus_error, halted}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("first_edge_fetch", {state, mem_req}, {3'd0, 1'b1});

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 8));
      issue({op, 12'($urandom)}, $urandom_range(0, 12), $urandom_range(0, 12));
    end
    issue(16'h200E, 0, 0);
    issue(16'h0123, 1, 3);
    issue(16'h8000, 2, 0);
    issue(16'h7000, 0, 0);
    issue(16'h5000, 4, 0);
    drain();

    // Starve FETCH: 15 unacknowledged cycles end in HALT with bus_error
    e = '0; e.kind = 2; e.berr = 1'b1; e.gap = -1; e.fetchrun = 15;
    exp_q.push_back(e);
    t = 0;
    while (!halted && t < 60) begin @(posedge clock); #1; t++; end
    drain();
    repeat (20) @(posedge clock);
    #1;
    check("halt_absorbing", {state, halted, bus_error}, {3'd5, 1'b1, 1'b1});
    pulse_reset();

    issue(16'hA000, 0, 0);
    drain();
    repeat (5) @(posedge clock);
    #1;
    check("illegal_stays_halted", {state, bus_error}, {3'd5, 1'b0});
    pulse_reset();

    issue(16'hF000, 3, 0);
    drain();
    pulse_reset();

    // Reset arriving while a data access is still outstanding
    serve(1'b0, 0, 16'h0000);
    t = 0;
    while (!(mem_req && mem_addr_sel) && t < 20) begin @(posedge clock); #1; t++; end
    check("reached_mem", {state, mem_addr_sel}, {3'd3, 1'b1});
    pulse_reset();
    repeat (3) @(posedge clock);
    #1;
    check("idle_after_reset", {state, exp_q.size() == 0}, {3'd0, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
